// File: rtl/etapa_pkg.sv
// Shared stage-1/stage-2 constants and the writer FSM state type.
package etapa_pkg;
  localparam int DATA_W  = 17;
  localparam int ADDR_W  = 8;
  localparam int N_WORDS = 144;

  typedef enum logic [1:0] {IDLE, FILL, DONE, HOLD} wr_state_t;
endpackage

// File: rtl/etapa1_bram_writer_if.sv
// Sample stream (valid/ready) and BRAM port-A write bus used by the stage-1 writer.
interface etapa_stream_if;
  import etapa_pkg::*;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

interface etapa_bram_if;
  import etapa_pkg::*;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (output wea, output addra, output dina);
  modport slave  (input wea, input addra, input dina);
endinterface

// File: rtl/etapa1_bram_writer.sv
// Fills one frame of N_WORDS samples into BRAM port A, then holds the buffer until
// the consumer has started and released it.
module etapa1_bram_writer
  import etapa_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  etapa_stream_if.slave  s,
  etapa_bram_if.master   bram,
  input  logic           busy,
  output logic           data_done,
  output logic           frame_err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              data_done_q, data_done_d;
  logic              frame_err_q, frame_err_d;
  logic              accept;
  logic              is_final;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!busy) state_d = FILL;
      FILL: begin
        if (accept) begin
          if (is_final)      state_d = DONE;
          else if (s.s_last) state_d = IDLE;
        end
      end
      DONE: state_d = HOLD;
      HOLD: if (busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A final word without s_last and an early s_last are both flagged; only the former completes.
  always_comb begin
    s.s_ready   = (state_q == FILL);
    accept      = s.s_valid && (state_q == FILL);
    is_final    = (wr_cnt_q == LAST_ADDR);
    wea_d       = accept;
    addra_d     = accept ? wr_cnt_q : addra_q;
    dina_d      = accept ? s.s_data : dina_q;
    frame_err_d = accept && (is_final ? !s.s_last : s.s_last);
    data_done_d = (state_q == DONE);
    wr_cnt_d    = wr_cnt_q;
    if (state_q == IDLE) wr_cnt_d = '0;
    else if (accept)     wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      data_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      data_done_q <= data_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bram.wea   = wea_q;
  assign bram.addra = addra_q;
  assign bram.dina  = dina_q;
  assign data_done  = data_done_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_etapa1_bram_writer.sv
// Frame-level bench for etapa1_bram_writer: table of frame scenarios plus hand-written
// hold-off and mid-frame reset sequences, checked against a BRAM image and event logs.
module tb_etapa1_bram_writer;
  import etapa_pkg::*;

  logic clk = 1'b0;
  logic reset, busy, data_done, frame_err;

  etapa_stream_if st();
  etapa_bram_if   bm();

  etapa1_bram_writer dut (
    .clk       (clk),
    .reset     (reset),
    .s         (st),
    .bram      (bm),
    .busy      (busy),
    .data_done (data_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int wr_addr[$], wr_data[$], wr_cyc[$], done_cyc[$], err_cyc[$];
  int exp_data[$];
  logic [DATA_W-1:0] mem [0:255];

  typedef struct {
    int len;
    bit last_on_end;
    int gap_pct;
    bit seq_data;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bm.wea) begin
        wr_addr.push_back(int'(bm.addra));
        wr_data.push_back(int'(bm.dina));
        wr_cyc.push_back(cyc);
        mem[bm.addra] = bm.dina;
      end
      if (data_done) done_cyc.push_back(cyc);
      if (frame_err) err_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc.delete(); err_cyc.delete();
  endtask

  // Drives n beats; the beat at index n-1 carries s_last when last_on_end is set.
  task automatic send_frame(input int n, input bit last_on_end, input int gap_pct,
                            input bit seq_data);
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      int d;
      int tmo;
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        @(negedge clk);
        st.s_valid = 1'b0;
      end
      d = seq_data ? i : int'($urandom & 32'h1FFFF);
      @(negedge clk);
      st.s_valid = 1'b1;
      st.s_data  = DATA_W'(d);
      st.s_last  = (i == n - 1) && last_on_end;
      tmo = 0;
      while (!st.s_ready) begin
        tmo = tmo + 1;
        if (tmo > 1000) begin
          chk("s_ready_timeout", 0, 1);
          st.s_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      exp_data.push_back(d);
    end
    @(negedge clk);
    st.s_valid = 1'b0;
    st.s_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input bit exp_done, input bit exp_err);
    int n;
    int bad;
    int lw;
    repeat (4) @(negedge clk);
    n   = exp_data.size();
    bad = 0;
    chk({tag, " write_count"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != exp_data[i]) bad++;
    chk({tag, " content_bad"}, bad, 0);
    chk({tag, " done_count"}, done_cyc.size(), exp_done);
    chk({tag, " err_count"}, err_cyc.size(), exp_err);
    if (wr_cyc.size() > 0) begin
      lw = wr_cyc[wr_cyc.size() - 1];
      if (exp_done && done_cyc.size() > 0) chk({tag, " done_latency"}, done_cyc[0] - lw, 1);
      if (exp_err && err_cyc.size() > 0)   chk({tag, " err_cycle"}, err_cyc[0] - lw, 0);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    busy = 1'b0;
  endtask

  initial begin
    int rdy;
    reset = 1'b1; busy = 1'b0;
    st.s_valid = 1'b0; st.s_data = '0; st.s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst wea", bm.wea, 0);
    chk("rst addra", bm.addra, 0);
    chk("rst dina", bm.dina, 0);
    chk("rst data_done", data_done, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst s_ready", st.s_ready, 0);
    reset = 1'b0;

    vecs[0] = '{len: 144, last_on_end: 1, gap_pct: 0,  seq_data: 1, exp_done: 1, exp_err: 0};
    vecs[1] = '{len: 144, last_on_end: 1, gap_pct: 30, seq_data: 0, exp_done: 1, exp_err: 0};
    vecs[2] = '{len: 51,  last_on_end: 1, gap_pct: 10, seq_data: 0, exp_done: 0, exp_err: 1};
    vecs[3] = '{len: 144, last_on_end: 0, gap_pct: 0,  seq_data: 0, exp_done: 1, exp_err: 1};
    vecs[4] = '{len: 1,   last_on_end: 1, gap_pct: 0,  seq_data: 0, exp_done: 0, exp_err: 1};
    vecs[5] = '{len: 144, last_on_end: 1, gap_pct: 50, seq_data: 0, exp_done: 1, exp_err: 0};

    for (int v = 0; v < 6; v++) begin
      clear_logs();
      send_frame(vecs[v].len, vecs[v].last_on_end, vecs[v].gap_pct, vecs[v].seq_data);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      if (v == 0) chk("portB addr77", mem[77], 77);
      if (vecs[v].exp_done) consume();
    end

    // Buffer lock: consumer busy for 300 cycles with the producer pushing.
    clear_logs();
    send_frame(144, 1, 20, 0);
    check_frame("hold_pre", 1, 0);
    clear_logs();
    @(negedge clk);
    busy = 1'b1;
    st.s_valid = 1'b1; st.s_data = 17'h1234; st.s_last = 1'b0;
    rdy = 0;
    repeat (300) begin
      @(negedge clk);
      if (st.s_ready) rdy++;
    end
    chk("hold s_ready_cycles", rdy, 0);
    chk("hold wea_count", wr_addr.size(), 0);
    busy = 1'b0;
    st.s_valid = 1'b0;
    send_frame(144, 1, 0, 0);
    check_frame("hold_post", 1, 0);
    consume();

    // Reset asserted while word 100 is on the write port.
    clear_logs();
    send_frame(100, 0, 0, 1);
    @(negedge clk);
    st.s_valid = 1'b1; st.s_data = DATA_W'(100); st.s_last = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst wea", bm.wea, 1);
    chk("pre_rst addra", bm.addra, 100);
    reset = 1'b1;
    #1;
    chk("async_rst wea", bm.wea, 0);
    chk("async_rst addra", bm.addra, 0);
    chk("async_rst s_ready", st.s_ready, 0);
    chk("async_rst data_done", data_done, 0);
    st.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    send_frame(144, 1, 0, 0);
    check_frame("post_rst", 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
